// File: rtl/tohost_monitor_pkg.sv
// Shared types and constants for the tohost test monitor: FSM states, the
// pass code and the widths of the tohost word and its test-number field.
package tohost_monitor_pkg;

  localparam int XLEN      = 32;
  localparam int TESTNUM_W = XLEN - 1;

  localparam logic [XLEN-1:0] PASS_CODE = 32'd1;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TMO
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i)               cnt_q <= '0;
    else if (en_i && cnt_q != '1)   cnt_q <= cnt_q + W'(1);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tohost_monitor.sv
// Holds the core in reset, then watches stores to the tohost word and
// reports pass/fail/timeout together with run-time cycle and retire counts.
module tohost_monitor
  import tohost_monitor_pkg::*;
#(
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int              TIMEOUT     = 5000,
  parameter int              RST_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [XLEN-1:0]      wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 retire,
  output logic                 core_rst,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [TESTNUM_W-1:0] fail_testnum,
  output logic [XLEN-1:0]      cycle_count,
  output logic [XLEN-1:0]      retire_count
);

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic                  done_q, pass_q, tmo_q;
  logic [TESTNUM_W-1:0]  fail_q;

  logic in_run, tohost_ev, expire;

  assign in_run    = (state_q == ST_RUN);
  assign tohost_ev = in_run && wr_en && (wr_addr == TOHOST_ADDR) && (wr_data != '0);
  // The count reaches TIMEOUT-1 on the same edge that moves us to TMO.
  assign expire    = in_run && (cycle_count == XLEN'(TIMEOUT - 2));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_HOLD: begin
        if (hold_q == HW'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (tohost_ev)   state_d = (wr_data == PASS_CODE) ? ST_PASS : ST_FAIL;
        else if (expire) state_d = ST_TMO;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HOLD;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      tmo_q  <= 1'b0;
      fail_q <= '0;
    end else if (in_run && state_d != ST_RUN) begin
      done_q <= 1'b1;
      pass_q <= (state_d == ST_PASS);
      tmo_q  <= (state_d == ST_TMO);
      if (state_d == ST_FAIL) fail_q <= wr_data[XLEN-1:1];
    end
  end

  sat_counter #(.W(XLEN)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_HOLD),
    .en_i  (in_run),
    .cnt_o (cycle_count)
  );

  sat_counter #(.W(XLEN)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_HOLD),
    .en_i  (in_run && retire),
    .cnt_o (retire_count)
  );

  assign core_rst     = (state_q == ST_HOLD);
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = tmo_q;
  assign fail_testnum = fail_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: a per-cycle vector table plus
// hand-written timeout, tie-break and mid-run reset sequences.
module tb_tohost_monitor;
  import tohost_monitor_pkg::*;

  localparam logic [31:0] TA = 32'h0000_1000;
  localparam int          TMO_LIM = 20;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_en = 1'b0;
  logic [XLEN-1:0]      wr_addr = '0;
  logic [XLEN-1:0]      wr_data = '0;
  logic                 retire = 1'b0;
  logic                 core_rst, done, pass, timeout;
  logic [TESTNUM_W-1:0] fail_testnum;
  logic [XLEN-1:0]      cycle_count, retire_count;

  int n_tests = 0;
  int n_fail  = 0;

  tohost_monitor #(
    .TOHOST_ADDR (TA),
    .TIMEOUT     (TMO_LIM),
    .RST_CYCLES  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .retire       (retire),
    .core_rst     (core_rst),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .fail_testnum (fail_testnum),
    .cycle_count  (cycle_count),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 rst, we;
    logic [31:0]          addr, data;
    logic                 ret;
    logic                 cr, dn, ps, to;
    logic [TESTNUM_W-1:0] ftn;
    logic [31:0]          cc, rc;
  } vec_t;

  function automatic vec_t mk(logic r, logic we, logic [31:0] a, logic [31:0] d, logic rt,
                              logic cr, logic dn, logic ps, logic to,
                              logic [TESTNUM_W-1:0] ftn, logic [31:0] cc, logic [31:0] rc);
    vec_t v;
    v.rst = r; v.we = we; v.addr = a; v.data = d; v.ret = rt;
    v.cr = cr; v.dn = dn; v.ps = ps; v.to = to; v.ftn = ftn; v.cc = cc; v.rc = rc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic cr, input logic dn, input logic ps,
                         input logic to, input logic [TESTNUM_W-1:0] ftn,
                         input logic [31:0] cc, input logic [31:0] rc);
    chk({tag, ".core_rst"},     32'(core_rst),     32'(cr));
    chk({tag, ".done"},         32'(done),         32'(dn));
    chk({tag, ".pass"},         32'(pass),         32'(ps));
    chk({tag, ".timeout"},      32'(timeout),      32'(to));
    chk({tag, ".fail_testnum"}, 32'(fail_testnum), 32'(ftn));
    chk({tag, ".cycle_count"},  cycle_count,       cc);
    chk({tag, ".retire_count"}, retire_count,      rc);
  endtask

  // Drive one cycle of inputs, clock it, and sample 1 time unit later.
  task automatic step(input logic r, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic rt);
    rst = r; wr_en = we; wr_addr = a; wr_data = d; retire = rt;
    @(posedge clk);
    #1;
  endtask

  // rst for one edge, then two HOLD edges: leaves the DUT in its first RUN cycle.
  task automatic restart();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  vec_t tv[24];

  initial begin
    tv[0]  = mk(1, 0, 0,      0,            0, 1, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(0, 1, TA,     PASS_CODE,    1, 1, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 0, 0,      0,            1, 0, 0, 0, 0, 0, 0, 0);
    tv[3]  = mk(0, 1, TA,     0,            1, 0, 0, 0, 0, 0, 1, 1);
    tv[4]  = mk(0, 1, TA + 4, 1,            0, 0, 0, 0, 0, 0, 2, 1);
    tv[5]  = mk(0, 0, TA,     1,            0, 0, 0, 0, 0, 0, 3, 1);
    tv[6]  = mk(0, 1, TA,     1,            1, 0, 1, 1, 0, 0, 4, 2);
    tv[7]  = mk(0, 1, TA,     7,            1, 0, 1, 1, 0, 0, 4, 2);
    tv[8]  = mk(0, 0, 0,      0,            0, 0, 1, 1, 0, 0, 4, 2);
    tv[9]  = mk(1, 0, 0,      0,            0, 1, 0, 0, 0, 0, 0, 0);
    tv[10] = mk(0, 0, 0,      0,            0, 1, 0, 0, 0, 0, 0, 0);
    tv[11] = mk(0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0, 0);
    tv[12] = mk(0, 0, 0,      0,            1, 0, 0, 0, 0, 0, 1, 1);
    tv[13] = mk(0, 1, TA,     7,            0, 0, 1, 0, 0, 3, 2, 1);
    tv[14] = mk(0, 1, TA,     1,            1, 0, 1, 0, 0, 3, 2, 1);
    tv[15] = mk(1, 0, 0,      0,            0, 1, 0, 0, 0, 0, 0, 0);
    tv[16] = mk(0, 0, 0,      0,            0, 1, 0, 0, 0, 0, 0, 0);
    tv[17] = mk(0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0, 0);
    tv[18] = mk(0, 1, TA,     32'h8000_0003, 0, 0, 1, 0, 0, 31'h4000_0001, 1, 0);
    tv[19] = mk(1, 0, 0,      0,            0, 1, 0, 0, 0, 0, 0, 0);
    tv[20] = mk(0, 0, 0,      0,            0, 1, 0, 0, 0, 0, 0, 0);
    tv[21] = mk(1, 0, 0,      0,            0, 1, 0, 0, 0, 0, 0, 0);
    tv[22] = mk(0, 0, 0,      0,            0, 1, 0, 0, 0, 0, 0, 0);
    tv[23] = mk(0, 0, 0,      0,            0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      step(tv[i].rst, tv[i].we, tv[i].addr, tv[i].data, tv[i].ret);
      chk_all($sformatf("vec%0d", i), tv[i].cr, tv[i].dn, tv[i].ps, tv[i].to,
              tv[i].ftn, tv[i].cc, tv[i].rc);
    end

    // Timeout: no stores, expect expiry after 19 RUN cycles with count 19.
    restart();
    begin
      int edges = 0;
      while (!done && edges < 40) begin
        step(0, 0, 0, 0, 0);
        edges++;
      end
      chk("tmo.edges", 32'(edges), 32'(TMO_LIM - 1));
      chk_all("tmo", 0, 1, 0, 1, 0, 32'(TMO_LIM - 1), 0);
      step(0, 1, TA, 1, 1);
      step(0, 0, 0, 0, 1);
      chk_all("tmo.hold", 0, 1, 0, 1, 0, 32'(TMO_LIM - 1), 0);
    end

    // Pass store in the expiry cycle: tohost wins.
    restart();
    for (int i = 0; i < TMO_LIM - 2; i++) step(0, 0, 0, 0, 0);
    chk_all("tie.pre", 0, 0, 0, 0, 0, 32'(TMO_LIM - 2), 0);
    step(0, 1, TA, PASS_CODE, 0);
    chk_all("tie", 0, 1, 1, 0, 0, 32'(TMO_LIM - 1), 0);

    // Mid-run reset after 10 RUN cycles with 5 retires.
    restart();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, (i < 5) ? 1'b1 : 1'b0);
    chk_all("mid.run", 0, 0, 0, 0, 0, 10, 5);
    step(1, 0, 0, 0, 1);
    chk_all("mid.rst", 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk_all("mid.hold", 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk_all("mid.run0", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk_all("mid.run1", 0, 0, 0, 0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tohost_monitor.md
TOHOST_MONITOR -- requirements
Module: tohost_monitor

Interface
REQ-001 The block SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, the byte address of the tohost word.
REQ-002 The block SHALL have parameter TIMEOUT, default 5000, the run-cycle limit before timeout.
REQ-003 The block SHALL have parameter RST_CYCLES, default 2, the number of cycles core_rst is held.
REQ-004 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port wr_en  input  1  core data-store strobe, one store per cycle.
REQ-007 The block SHALL have port wr_addr  input  32  store byte address.
REQ-008 The block SHALL have port wr_data  input  32  store data.
REQ-009 The block SHALL have port retire  input  1  one-cycle pulse per retired instruction.
REQ-010 The block SHALL have port core_rst  output  1  reset driven to the core.
REQ-011 The block SHALL have port done  output  1  test finished (pass, fail or timeout), sticky.
REQ-012 The block SHALL have port pass  output  1  test passed, valid when done.
REQ-013 The block SHALL have port timeout  output  1  watchdog expired, valid when done.
REQ-014 The block SHALL have port fail_testnum  output  31  failing test number (wr_data[31:1]), valid when done and not pass.
REQ-015 The block SHALL have port cycle_count  output  32  cycles spent in RUN.
REQ-016 The block SHALL have port retire_count  output  32  instructions retired in RUN.

Function
REQ-017 The FSM SHALL have states HOLD, RUN, PASS, FAIL, TMO; PASS, FAIL and TMO are terminal until rst.
REQ-018 In HOLD, core_rst SHALL be 1; after exactly RST_CYCLES cycles in HOLD the FSM SHALL move to RUN, and core_rst SHALL be 0 from the first RUN cycle.
REQ-019 In RUN, a store with wr_en=1, wr_addr==TOHOST_ADDR and wr_data!=0 SHALL be a tohost event.
REQ-020 On a tohost event with wr_data==1 the FSM SHALL enter PASS; with any other non-zero value it SHALL enter FAIL and latch fail_testnum=wr_data[31:1].
REQ-021 Stores with wr_data==0, to any other address (including TOHOST_ADDR+4), or made outside RUN SHALL be ignored.
REQ-022 done, pass, timeout and fail_testnum SHALL be registered and SHALL update in the cycle after the triggering event.
REQ-023 cycle_count SHALL increment once per RUN cycle; when it reaches TIMEOUT-1 without a tohost event, the FSM SHALL enter TMO.
REQ-024 If a tohost event and timeout expiry occur in the same cycle, the tohost event SHALL win.
REQ-025 retire_count SHALL increment on retire only in RUN; retire pulses in HOLD or a terminal state SHALL be ignored.
REQ-026 Both counters SHALL saturate at 32'hFFFF_FFFF and SHALL freeze on leaving RUN.
REQ-027 In terminal states core_rst SHALL stay 0 and all outputs SHALL hold their values.

Reset
REQ-028 On rst=1 at a clock edge the FSM SHALL enter HOLD with core_rst=1, done=0, pass=0, timeout=0, fail_testnum=0, cycle_count=0, retire_count=0, including when rst arrives mid-RUN or in a terminal state.
REQ-029 The HOLD cycle count SHALL restart from zero on every rst cycle, so the HOLD interval is measured from rst deassertion.

Structure
REQ-030 The state enum, the pass code value (1) and the tohost-field widths SHALL live in a shared package used by the bench and the monitor.
REQ-031 Both counters SHALL use one sub-module, sat_counter (32-bit, enable, synchronous clear, saturating).

Verification
REQ-032 Reset release: rst high 1 cycle, then low -> core_rst=1 for exactly 2 cycles, then 0; cycle_count starts at 0 in the first RUN cycle.
REQ-033 Pass: in RUN, store 0x1 to 0x1000 -> next cycle done=1, pass=1, timeout=0; counters frozen thereafter.
REQ-034 Fail: store 0x0000_0007 to 0x1000 -> done=1, pass=0, fail_testnum=3; a later store of 0x1 -> no change.
REQ-035 Ignored writes: store 0 to 0x1000, store 0x1 to 0x1004, store 0x1 to 0x1000 during HOLD -> done stays 0.
REQ-036 Timeout: TIMEOUT=20, no stores -> done=1, timeout=1, cycle_count=19; a separate run with the pass store in the expiry cycle -> pass=1, timeout=0.
REQ-037 Mid-run reset: rst asserted after 10 RUN cycles with 5 retires -> all outputs cleared, core_rst=1; retire pulses during HOLD -> retire_count stays 0.
